// File: rtl/fc_logits.sv
// Serial fully-connected logit layer: NUM_CLASSES parallel MACs over IN_LEN beats, then shift/saturate/pack.
// Optional FC_BIAS_EN macro adds a per-class bias port and bias term before scaling.
module fc_logits #(
   parameter int IN_LEN      = 64,
   parameter int NUM_CLASSES = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8,
   parameter int ACC_WIDTH   = 40
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH-1:0]             feat_in,
   input  logic [NUM_CLASSES*DATA_WIDTH-1:0] weight_in,
`ifdef FC_BIAS_EN
   input  logic [NUM_CLASSES*DATA_WIDTH-1:0] bias_in,
`endif
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [NUM_CLASSES*DATA_WIDTH-1:0] logits_out,
   output logic [NUM_CLASSES-1:0]            sat_out
);

   localparam int CNT_W = $clog2(IN_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_LEN - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {ST_ACCUM, ST_FINISH, ST_OUT} state_t;

   state_t                              state_q, state_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic                                in_ready_q, in_ready_d;
   logic                                out_valid_q, out_valid_d;
   logic [NUM_CLASSES*DATA_WIDTH-1:0]   logits_q, logits_d;
   logic [NUM_CLASSES-1:0]              sat_q, sat_d;
   logic signed [ACC_WIDTH-1:0]         acc_q [NUM_CLASSES];
   logic signed [ACC_WIDTH-1:0]         acc_d [NUM_CLASSES];
   logic signed [ACC_WIDTH-1:0]         fin_acc [NUM_CLASSES];
   logic [DATA_WIDTH:0]                 fin_res [NUM_CLASSES];

   // Full-width signed product, sign-extended into the accumulator.
   function automatic logic signed [ACC_WIDTH-1:0] mac(
      input logic signed [ACC_WIDTH-1:0]  acc,
      input logic signed [DATA_WIDTH-1:0] f,
      input logic signed [DATA_WIDTH-1:0] w
   );
      logic signed [2*DATA_WIDTH-1:0] prod;
      prod = (2*DATA_WIDTH)'(f) * (2*DATA_WIDTH)'(w);
      return acc + ACC_WIDTH'(prod);
   endfunction

   // Returns {clipped, value} for a value already in logit scale.
   function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
      if (v > SAT_MAX)
         return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
      else if (v < SAT_MIN)
         return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
      else
         return {1'b0, v[DATA_WIDTH-1:0]};
   endfunction

   function automatic logic [DATA_WIDTH:0] finish_logit(input logic signed [ACC_WIDTH-1:0] acc);
      return saturate(acc >>> FRAC_BITS);
   endfunction

   // Finish-stage operand: accumulator plus optional bias aligned to the Q point.
   always_comb begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
         fin_acc[k] = acc_q[k];
`ifdef FC_BIAS_EN
         fin_acc[k] = acc_q[k] +
            (ACC_WIDTH'($signed(bias_in[k*DATA_WIDTH +: DATA_WIDTH])) <<< FRAC_BITS);
`endif
         fin_res[k] = finish_logit(fin_acc[k]);
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      logits_d    = logits_q;
      sat_d       = sat_q;
      for (int k = 0; k < NUM_CLASSES; k++)
         acc_d[k] = acc_q[k];

      case (state_q)
         ST_ACCUM: begin
            if (in_valid && in_ready_q) begin
               for (int k = 0; k < NUM_CLASSES; k++)
                  acc_d[k] = mac(acc_q[k], feat_in, weight_in[k*DATA_WIDTH +: DATA_WIDTH]);
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_FINISH;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_FINISH: begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
               logits_d[k*DATA_WIDTH +: DATA_WIDTH] = fin_res[k][DATA_WIDTH-1:0];
               sat_d[k] = fin_res[k][DATA_WIDTH];
            end
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               for (int k = 0; k < NUM_CLASSES; k++)
                  acc_d[k] = '0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      // Registered ready keeps in_ready low during reset and for one edge after it.
      in_ready_d = (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         logits_q    <= '0;
         sat_q       <= '0;
         for (int k = 0; k < NUM_CLASSES; k++)
            acc_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         logits_q    <= logits_d;
         sat_q       <= sat_d;
         for (int k = 0; k < NUM_CLASSES; k++)
            acc_q[k] <= acc_d[k];
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign logits_out = logits_q;
   assign sat_out    = sat_q;

endmodule

// File: tb/tb_fc_logits.sv
// Directed self-checking bench for fc_logits (default parameters; bias test under FC_BIAS_EN).
module tb_fc_logits;
   localparam int IN_LEN = 64;
   localparam int NC     = 8;
   localparam int DW     = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   feat_in;
   logic [NC*DW-1:0] weight_in;
`ifdef FC_BIAS_EN
   logic [NC*DW-1:0] bias_in;
`endif
   logic            out_valid;
   logic            out_ready;
   logic [NC*DW-1:0] logits_out;
   logic [NC-1:0]   sat_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0]    feat_v [IN_LEN];
   logic [NC*DW-1:0] wt_v   [IN_LEN];

   always #5 clk = ~clk;

   fc_logits dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .feat_in    (feat_in),
      .weight_in  (weight_in),
`ifdef FC_BIAS_EN
      .bias_in    (bias_in),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .logits_out (logits_out),
      .sat_out    (sat_out)
   );

   function automatic logic [NC*DW-1:0] pack8(input int a0, input int a1, input int a2,
      input int a3, input int a4, input int a5, input int a6, input int a7);
      return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   task automatic fill_uniform(input int f, input logic [NC*DW-1:0] w);
      for (int i = 0; i < IN_LEN; i++) begin
         feat_v[i] = 16'(f);
         wt_v[i]   = w;
      end
   endtask

   // Called at a negedge; returns at the negedge following the last accepted beat.
   task automatic drive_frame(input int nbeats, input bit gaps, output bit ok);
      int g;
      int t;
      ok = 1'b1;
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
               in_valid  = 1'b0;
               feat_in   = 16'h7fff;
               weight_in = '1;
               @(negedge clk);
            end
         end
         in_valid  = 1'b1;
         feat_in   = feat_v[i];
         weight_in = wt_v[i];
         t = 0;
         while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) ok = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      int t;
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++;
      if (logits_out !== '0) begin n_fail++; $display("FAIL reset_logits got %h want 0", logits_out); end
      n_checks++;
      if (sat_out !== '0) begin n_fail++; $display("FAIL reset_sat got %h want 0", sat_out); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge got %b want 0", in_ready); end
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge got %b want 1", in_ready); end
   endtask

   task automatic test_full_scale;
      bit ok;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(0, 16384, 32767, 32767, 32767, 32767, 32767, 32767);
      fill_uniform(256, pack8(0, 256, 512, 768, 1024, 1280, 1536, 1792));
      out_ready = 1'b1;
      drive_frame(IN_LEN, 1'b0, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL full_beats_accepted got 0 want 1"); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_finish got %b want 0", out_valid); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency got %b want 1", out_valid); end
      n_checks++;
      if (logits_out !== exp_l) begin n_fail++; $display("FAIL full_logits got %h want %h", logits_out, exp_l); end
      n_checks++;
      if (sat_out !== 8'b1111_1100) begin n_fail++; $display("FAIL full_sat got %b want 11111100", sat_out); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_pulse got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_negative;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(-64, -64, -64, -64, -64, -64, -64, -64);
      fill_uniform(-256, pack8(1, 1, 1, 1, 1, 1, 1, 1));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv)) begin n_fail++; $display("FAIL neg_timeout got %b%b want 11", ok, okv); end
      n_checks++;
      if (logits_out !== exp_l) begin n_fail++; $display("FAIL neg_logits got %h want %h", logits_out, exp_l); end
      n_checks++;
      if (sat_out !== '0) begin n_fail++; $display("FAIL neg_sat got %b want 0", sat_out); end
      @(negedge clk);
   endtask

   task automatic test_truncation;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(0, -1, -1, -1, -1, -2, -2, -2);
      fill_uniform(-1, pack8(0, 1, 2, 3, 4, 5, 6, 7));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv)) begin n_fail++; $display("FAIL trunc_timeout got %b%b want 11", ok, okv); end
      n_checks++;
      if (logits_out !== exp_l || sat_out !== '0) begin
         n_fail++; $display("FAIL trunc_logits got %h/%b want %h/0", logits_out, sat_out, exp_l);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation_mixed;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(-32768, 32767, 0, -8192, 8192, -32768, 32767, -16384);
      fill_uniform(-32768, pack8(32767, -32768, 0, 1, -1, 4, -4, 2));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv)) begin n_fail++; $display("FAIL mixsat_timeout got %b%b want 11", ok, okv); end
      n_checks++;
      if (logits_out !== exp_l) begin n_fail++; $display("FAIL mixsat_logits got %h want %h", logits_out, exp_l); end
      n_checks++;
      if (sat_out !== 8'b0100_0011) begin n_fail++; $display("FAIL mixsat_sat got %b want 01000011", sat_out); end
      @(negedge clk);
   endtask

   task automatic test_back_pressure;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(-8064, -6048, -4032, -2016, 0, 2016, 4032, 6048);
      for (int i = 0; i < IN_LEN; i++) begin
         feat_v[i] = 16'(i);
         wt_v[i]   = pack8(-1024, -768, -512, -256, 0, 256, 512, 768);
      end
      out_ready = 1'b0;
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv)) begin n_fail++; $display("FAIL bp_timeout got %b%b want 11", ok, okv); end
      n_checks++;
      if (logits_out !== exp_l) begin n_fail++; $display("FAIL bp_logits got %h want %h", logits_out, exp_l); end
      for (int c = 0; c < 10; c++) begin
         in_valid  = 1'b1;
         feat_in   = 16'd1000;
         weight_in = '1;
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || logits_out !== exp_l || sat_out !== '0) begin
            n_fail++;
            $display("FAIL bp_hold c=%0d got v=%b r=%b l=%h s=%b want 1/0/%h/0",
                     c, out_valid, in_ready, logits_out, sat_out, exp_l);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", out_valid); end
      exp_l = pack8(-64, -64, -64, -64, -64, -64, -64, -64);
      fill_uniform(-256, pack8(1, 1, 1, 1, 1, 1, 1, 1));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv) || logits_out !== exp_l) begin
         n_fail++; $display("FAIL bp_next_frame got %h want %h", logits_out, exp_l);
      end
      @(negedge clk);
   endtask

   task automatic test_gaps;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l = pack8(0, 16384, 32767, 32767, 32767, 32767, 32767, 32767);
      fill_uniform(256, pack8(0, 256, 512, 768, 1024, 1280, 1536, 1792));
      drive_frame(IN_LEN, 1'b1, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv)) begin n_fail++; $display("FAIL gaps_timeout got %b%b want 11", ok, okv); end
      n_checks++;
      if (logits_out !== exp_l || sat_out !== 8'b1111_1100) begin
         n_fail++; $display("FAIL gaps_logits got %h/%b want %h/11111100", logits_out, sat_out, exp_l);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_recover;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      fill_uniform(12345, pack8(300, -300, 700, -700, 32767, -32768, 5, 9));
      drive_frame(30, 1'b0, ok);
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midreset got r=%b v=%b want 0/0", in_ready, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      fill_uniform(-256, pack8(1, 1, 1, 1, 1, 1, 1, 1));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || logits_out !== '0) begin
         n_fail++; $display("FAIL outreset got v=%b l=%h want 0/0", out_valid, logits_out);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      exp_l = pack8(0, -1, -1, -1, -1, -2, -2, -2);
      fill_uniform(-1, pack8(0, 1, 2, 3, 4, 5, 6, 7));
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv) || logits_out !== exp_l || sat_out !== '0) begin
         n_fail++; $display("FAIL reset_clean_frame got %h/%b want %h/0", logits_out, sat_out, exp_l);
      end
      @(negedge clk);
   endtask

`ifdef FC_BIAS_EN
   task automatic test_bias;
      bit ok, okv;
      logic [NC*DW-1:0] exp_l;
      exp_l   = pack8(-4, -3, -2, -1, 0, 1, 2, 3);
      bias_in = pack8(-4, -3, -2, -1, 0, 1, 2, 3);
      fill_uniform(100, '0);
      drive_frame(IN_LEN, 1'b0, ok);
      wait_valid(okv);
      n_checks++;
      if (!(ok && okv) || logits_out !== exp_l || sat_out !== '0) begin
         n_fail++; $display("FAIL bias_logits got %h/%b want %h/0", logits_out, sat_out, exp_l);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      feat_in   = '0;
      weight_in = '0;
`ifdef FC_BIAS_EN
      bias_in   = '0;
`endif
      test_reset();
      test_full_scale();
      test_negative();
      test_truncation();
      test_saturation_mixed();
      test_back_pressure();
      test_gaps();
      test_reset_recover();
`ifdef FC_BIAS_EN
      test_bias();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
